// File: rtl/mixer_pkg.sv
// Shared colours, report flag indices and report FSM states for sprite_collision_mixer.
package mixer_pkg;

    localparam logic [2:0] COL_TANK1 = 3'b011;
    localparam logic [2:0] COL_TANK2 = 3'b110;
    localparam logic [2:0] COL_PF    = 3'b100;
    localparam logic [2:0] COL_BG    = 3'b000;
    localparam logic [2:0] COL_FLASH = 3'b111;

    localparam int FLAG_T1_PF = 0;
    localparam int FLAG_T2_PF = 1;
    localparam int FLAG_T1_T2 = 2;

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } rpt_state_e;

    function automatic logic [2:0] prio_colour(input logic t1, input logic t2, input logic pf);
        logic [2:0] c;
        c = COL_BG;
        if (t1)      c = COL_TANK1;
        else if (t2) c = COL_TANK2;
        else if (pf) c = COL_PF;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together load 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = inc ? W'(1) : '0;
        else if (inc && (q_q != '1))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sprite_collision_mixer.sv
// Priority pixel mixer with per-frame collision counters and a valid/ack frame report.
// Optional build macro COLLISION_FLASH_EN makes colliding tanks flash white.
module sprite_collision_mixer
    import mixer_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int COLLIDE_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             display_on,
    input  logic             vsync,
    input  logic             tank1_gfx,
    input  logic             tank2_gfx,
    input  logic             playfield_gfx,
    output logic [2:0]       rgb,
    output logic             report_valid,
    input  logic             report_ack,
    output logic [2:0]       report_flags,
    output logic [CNT_W-1:0] report_t1_pf,
    output logic [CNT_W-1:0] report_t2_pf,
    output logic [CNT_W-1:0] report_t1_t2,
    output logic             report_overrun
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(COLLIDE_THRESH);

    logic disp_q, t1_q, t2_q, pf_q, vsync_q;
    logic disp_d, t1_d, t2_d, pf_d, vsync_d;
    logic [2:0] rgb_q, rgb_d;

    always_comb begin
        disp_d  = display_on;
        t1_d    = tank1_gfx;
        t2_d    = tank2_gfx;
        pf_d    = playfield_gfx;
        vsync_d = vsync;
    end

    // Stage 1: input capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q  <= 1'b0;
            t1_q    <= 1'b0;
            t2_q    <= 1'b0;
            pf_q    <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            disp_q  <= disp_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            pf_q    <= pf_d;
            vsync_q <= vsync_d;
        end
    end

    logic frame_end;
    logic inc_t1_pf, inc_t2_pf, inc_t1_t2;
    logic [CNT_W-1:0] cnt_t1_pf, cnt_t2_pf, cnt_t1_t2;

    assign frame_end = vsync & ~vsync_q;
    assign inc_t1_pf = disp_q & t1_q & pf_q;
    assign inc_t2_pf = disp_q & t2_q & pf_q;
    assign inc_t1_t2 = disp_q & t1_q & t2_q;

    sat_counter #(.W(CNT_W)) u_cnt_t1_pf (
        .clk(clk), .reset(reset), .inc(inc_t1_pf), .clr(frame_end), .q(cnt_t1_pf)
    );
    sat_counter #(.W(CNT_W)) u_cnt_t2_pf (
        .clk(clk), .reset(reset), .inc(inc_t2_pf), .clr(frame_end), .q(cnt_t2_pf)
    );
    sat_counter #(.W(CNT_W)) u_cnt_t1_t2 (
        .clk(clk), .reset(reset), .inc(inc_t1_t2), .clr(frame_end), .q(cnt_t1_t2)
    );

    logic [2:0]       flags_q, flags_d;
    logic [CNT_W-1:0] rpt_t1_pf_q, rpt_t1_pf_d;
    logic [CNT_W-1:0] rpt_t2_pf_q, rpt_t2_pf_d;
    logic [CNT_W-1:0] rpt_t1_t2_q, rpt_t1_t2_d;
    logic             overrun_q, overrun_d;

`ifdef COLLISION_FLASH_EN
    logic [3:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end) frame_cnt_d = frame_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_cnt_q <= 4'd0;
        else       frame_cnt_q <= frame_cnt_d;
    end
`endif

    always_comb begin
        rgb_d = COL_BG;
        if (disp_q) begin
            rgb_d = prio_colour(t1_q, t2_q, pf_q);
`ifdef COLLISION_FLASH_EN
            if (t1_q && t2_q)
                rgb_d = COL_FLASH;
            else if ((t1_q || t2_q) && flags_q[FLAG_T1_T2] && frame_cnt_q[2])
                rgb_d = COL_FLASH;
`endif
        end
    end

    // Stage 2: pixel output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rgb_q <= COL_BG;
        else       rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;

    rpt_state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (frame_end) state_d = PENDING;
            PENDING: if (report_ack && !frame_end) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        report_valid = (state_q == PENDING);
    end

    // Snapshot uses pre-increment counts; the counters themselves handle the reload.
    always_comb begin
        flags_d     = flags_q;
        rpt_t1_pf_d = rpt_t1_pf_q;
        rpt_t2_pf_d = rpt_t2_pf_q;
        rpt_t1_t2_d = rpt_t1_t2_q;
        overrun_d   = overrun_q;
        if (frame_end) begin
            rpt_t1_pf_d            = cnt_t1_pf;
            rpt_t2_pf_d            = cnt_t2_pf;
            rpt_t1_t2_d            = cnt_t1_t2;
            flags_d[FLAG_T1_PF]    = (cnt_t1_pf >= THRESH);
            flags_d[FLAG_T2_PF]    = (cnt_t2_pf >= THRESH);
            flags_d[FLAG_T1_T2]    = (cnt_t1_t2 >= THRESH);
            overrun_d              = (state_q == PENDING) && !report_ack;
        end else if ((state_q == PENDING) && report_ack) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= '0;
            rpt_t1_pf_q <= '0;
            rpt_t2_pf_q <= '0;
            rpt_t1_t2_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            rpt_t1_pf_q <= rpt_t1_pf_d;
            rpt_t2_pf_q <= rpt_t2_pf_d;
            rpt_t1_t2_q <= rpt_t1_t2_d;
            overrun_q   <= overrun_d;
        end
    end

    assign report_flags   = flags_q;
    assign report_t1_pf   = rpt_t1_pf_q;
    assign report_t2_pf   = rpt_t2_pf_q;
    assign report_t1_t2   = rpt_t1_t2_q;
    assign report_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_collision_mixer.sv
// Scoreboard bench for sprite_collision_mixer (default build, CNT_W=8, COLLIDE_THRESH=2).
module tb_sprite_collision_mixer;

    localparam int CNT_W  = 8;
    localparam int THRESH = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             display_on, vsync, tank1_gfx, tank2_gfx, playfield_gfx, report_ack;
    logic [2:0]       rgb;
    logic             report_valid;
    logic [2:0]       report_flags;
    logic [CNT_W-1:0] report_t1_pf, report_t2_pf, report_t1_t2;
    logic             report_overrun;

    always #5 clk = ~clk;

    sprite_collision_mixer #(.CNT_W(CNT_W), .COLLIDE_THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .display_on(display_on), .vsync(vsync),
        .tank1_gfx(tank1_gfx), .tank2_gfx(tank2_gfx), .playfield_gfx(playfield_gfx),
        .rgb(rgb), .report_valid(report_valid), .report_ack(report_ack),
        .report_flags(report_flags), .report_t1_pf(report_t1_pf),
        .report_t2_pf(report_t2_pf), .report_t1_t2(report_t1_t2),
        .report_overrun(report_overrun)
    );

    typedef struct {
        logic [2:0] flags;
        int         c1;
        int         c2;
        int         c12;
    } rpt_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] rgb_exp[$];
    rpt_t       rpt_exp[$];

    int   m_c1, m_c2, m_c12;
    logic p_t1pf, p_t2pf, p_t1t2;
    logic prev_vs, m_valid, m_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    function automatic logic [2:0] exp_colour(input logic d, input logic t1, input logic t2, input logic pf);
        if (!d)  return 3'b000;
        if (t1)  return 3'b011;
        if (t2)  return 3'b110;
        if (pf)  return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_clear();
        m_c1 = 0; m_c2 = 0; m_c12 = 0;
        p_t1pf = 0; p_t2pf = 0; p_t1t2 = 0;
        prev_vs = 0; m_valid = 0; m_ov = 0;
        rgb_exp.delete();
        rpt_exp.delete();
    endtask

    // One pixel clock: drive, update the reference model, then check after the edge.
    task automatic cycle(input logic d, input logic t1, input logic t2, input logic pf,
                         input logic vs, input logic ack);
        logic fe;
        rpt_t r;
        display_on = d; tank1_gfx = t1; tank2_gfx = t2; playfield_gfx = pf;
        vsync = vs; report_ack = ack;
        rgb_exp.push_back(exp_colour(d, t1, t2, pf));
        fe = vs & ~prev_vs;
        prev_vs = vs;
        if (fe) begin
            r.c1 = m_c1; r.c2 = m_c2; r.c12 = m_c12;
            r.flags = {m_c12 >= THRESH, m_c2 >= THRESH, m_c1 >= THRESH};
            rpt_exp.push_back(r);
            m_c1  = p_t1pf ? 1 : 0;
            m_c2  = p_t2pf ? 1 : 0;
            m_c12 = p_t1t2 ? 1 : 0;
            if (!m_valid) begin
                m_valid = 1; m_ov = 0;
            end else begin
                m_ov = !ack;
            end
        end else begin
            if (p_t1pf) m_c1  = sat_inc(m_c1);
            if (p_t2pf) m_c2  = sat_inc(m_c2);
            if (p_t1t2) m_c12 = sat_inc(m_c12);
            if (m_valid && ack) begin
                m_valid = 0; m_ov = 0;
            end
        end
        p_t1pf = d & t1 & pf;
        p_t2pf = d & t2 & pf;
        p_t1t2 = d & t1 & t2;
        @(posedge clk);
        #1;
        if (rgb_exp.size() >= 2) chk("rgb", rgb, rgb_exp.pop_front());
        chk("report_valid", report_valid, m_valid);
        chk("report_overrun", report_overrun, m_ov);
        if (fe) begin
            r = rpt_exp.pop_front();
            chk("report_flags", report_flags, r.flags);
            chk("report_t1_pf", report_t1_pf, r.c1);
            chk("report_t2_pf", report_t2_pf, r.c2);
            chk("report_t1_t2", report_t1_t2, r.c12);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic vsync_pulse(input logic ack_at_rise);
        cycle(0, 0, 0, 0, 1, ack_at_rise);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ack1();
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        display_on = 0; vsync = 0; tank1_gfx = 0; tank2_gfx = 0;
        playfield_gfx = 0; report_ack = 0;
        #1;
        chk("rst_rgb", rgb, 0);
        chk("rst_valid", report_valid, 0);
        chk("rst_flags", report_flags, 0);
        chk("rst_t1_pf", report_t1_pf, 0);
        chk("rst_t2_pf", report_t2_pf, 0);
        chk("rst_t1_t2", report_t1_t2, 0);
        chk("rst_overrun", report_overrun, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset();

        // priority patterns
        cycle(1, 1, 1, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0);
        idle(2);
        vsync_pulse(0);
        ack1();

        // threshold: one pixel then two
        cycle(1, 1, 0, 1, 0, 0);
        idle(2);
        vsync_pulse(0);
        chk("thr1_flags", report_flags, 3'b000);
        chk("thr1_cnt", report_t1_pf, 1);
        ack1();
        cycle(1, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        idle(2);
        vsync_pulse(0);
        chk("thr2_flags", report_flags, 3'b001);
        chk("thr2_cnt", report_t1_pf, 2);
        ack1();

        // saturation
        for (int i = 0; i < 300; i++) cycle(1, 0, 1, 1, 0, 0);
        idle(2);
        vsync_pulse(0);
        chk("sat_cnt", report_t2_pf, 255);
        chk("sat_flag", report_flags[1], 1);
        ack1();

        // overrun: two frame ends without ack
        cycle(1, 1, 1, 0, 0, 0);
        idle(2);
        vsync_pulse(0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);
        idle(2);
        vsync_pulse(0);
        chk("ovr_flag", report_overrun, 1);
        chk("ovr_cnt", report_t1_t2, 3);
        ack1();
        chk("ack_valid", report_valid, 0);
        chk("ack_overrun", report_overrun, 0);

        // ack coincident with frame end
        vsync_pulse(0);
        cycle(1, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        idle(2);
        vsync_pulse(1);
        chk("sim_valid", report_valid, 1);
        chk("sim_overrun", report_overrun, 0);
        chk("sim_cnt", report_t1_pf, 2);
        ack1();

        // reset mid-frame discards partial counts
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0, 0);
        idle(2);
        vsync_pulse(0);
        chk("post_rst_cnt", report_t1_pf, 3);
        ack1();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
